semaphore_client: RTL and testbench
===================================

SEMAPHORE_CLIENT -- requirements
Module: semaphore_client

Interface
REQ-001 Parameter NumberOfSemaphores, default 4, number of semaphores in the attached array (>=2).
REQ-002 Parameter TimeoutCycles, default 255, max blocked cycles before acquire is abandoned; 0 disables timeout.
REQ-003 IdWidth = clog2(NumberOfSemaphores) is a derived constant, not overridable.
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 SEMCLIENT_RESET  input  1  asynchronous, active-high reset.
REQ-006 SEMCLIENT_REQ  input  1  core request strobe, sampled only in IDLE.
REQ-007 SEMCLIENT_OP  input  1  0 = acquire (P), 1 = release (V).
REQ-008 SEMCLIENT_ID  input  IdWidth  target semaphore index.
REQ-009 SEMCLIENT_BUSY  output  1  core stall, high in every non-IDLE state.
REQ-010 SEMCLIENT_DONE  output  1  one-cycle pulse on successful acquire or release.
REQ-011 SEMCLIENT_TIMEOUT  output  1  one-cycle pulse when acquire is abandoned.
REQ-012 SEMCLIENT_ERR  output  1  one-cycle pulse on out-of-range ID.
REQ-013 SEMCLIENT_EN  output  NumberOfSemaphores  one-hot enable into this core's slice of the array.
REQ-014 SEMCLIENT_WR  output  NumberOfSemaphores  one-hot write strobe into the array.
REQ-015 SEMCLIENT_BLOCKING  input  NumberOfSemaphores  per-semaphore blocking from the array for this core.

Function
REQ-016 States: IDLE, ACQ_WAIT, ACQ_TAKE, REL, TOUT, ERR; all outputs decoded from registered state, latched ID and latched OP.
REQ-017 IDLE with REQ=1: latch ID/OP; ID>=NumberOfSemaphores -> ERR; else OP=0 -> ACQ_WAIT, OP=1 -> REL; timeout counter cleared.
REQ-018 IDLE with REQ=0: remain; all outputs 0.
REQ-019 ACQ_WAIT: EN[id]=1, WR=0; BLOCKING[id]=0 -> ACQ_TAKE; else counter +1.
REQ-020 ACQ_WAIT: BLOCKING[id]=1 and counter==TimeoutCycles-1 (TimeoutCycles!=0) -> TOUT.
REQ-021 Same-cycle BLOCKING[id] release and timeout limit: acquire wins, go ACQ_TAKE.
REQ-022 ACQ_TAKE (one cycle): EN[id]=1, WR[id]=1, DONE=1; -> IDLE.
REQ-023 REL (one cycle): EN=0, WR[id]=1, DONE=1; -> IDLE.
REQ-024 TOUT (one cycle): EN=0, WR=0, TIMEOUT=1; -> IDLE.
REQ-025 ERR (one cycle): EN=0, WR=0, ERR=1; -> IDLE.
REQ-026 Uncontended acquire: REQ sampled edge k -> ACQ_WAIT cycle k+1 -> ACQ_TAKE k+2 -> IDLE k+3, new REQ accepted at edge k+3.
REQ-027 Release: REQ at edge k -> REL cycle k+1 -> IDLE k+2.
REQ-028 REQ, OP, ID ignored while BUSY=1; no queuing.
REQ-029 EN and WR never have more than one bit set; bits other than latched ID always 0.
REQ-030 Timeout counter width clog2(TimeoutCycles+1), saturates, never wraps.
REQ-031 BLOCKING bits other than latched ID have no effect.

Reset
REQ-032 Reset asserted: state IDLE, counter 0, latched ID/OP 0, all outputs 0, asynchronously.
REQ-033 Reset mid-operation (any state) aborts with no WR, DONE, TIMEOUT or ERR pulse issued.
REQ-034 First REQ accepted at first rising edge after reset deasserts.

Structure
REQ-035 Package semaphore_pkg holds state encoding, OP encodings (ACQUIRE=0, RELEASE=1), IdWidth derivation.
REQ-036 One sub-module semaphore_timeout_cnt: clear, enable, saturating count, terminal-count flag.
REQ-037 FSM and one-hot decode stay in semaphore_client; RTL target 150-250 lines.

Verification
REQ-038 Reset, ID=2, OP=0, BLOCKING=0 -> EN=0100 cycles k+1,k+2; WR=0100 and DONE at k+2; BUSY low k+3.
REQ-039 ID=1, OP=0, BLOCKING[1]=1 for 5 cycles then 0, TimeoutCycles=255 -> 5 wait cycles, then WR=0010+DONE, no TIMEOUT.
REQ-040 TimeoutCycles=8, ID=3, BLOCKING[3] held 1 -> TIMEOUT pulse exactly 8 cycles after ACQ_WAIT entry, WR never set.
REQ-041 ID=0, OP=1 -> WR=0001, EN=0000, DONE one cycle at k+1; REQ pulsed during BUSY ignored.
REQ-042 NumberOfSemaphores=3, ID=3 -> ERR pulse k+1, EN/WR 0; reset asserted in ACQ_WAIT -> all outputs 0 same cycle.

Source files
------------

// File: rtl/semaphore_pkg.sv
// Shared types and helpers for the semaphore client.
// State encoding, operation codes and width derivations.
package semaphore_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACQ_WAIT,
        S_ACQ_TAKE,
        S_REL,
        S_TOUT,
        S_ERR
    } state_t;

    localparam logic OP_ACQUIRE = 1'b0;
    localparam logic OP_RELEASE = 1'b1;

    // Index width for a semaphore array of n entries.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Counter width able to hold the value t.
    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/semaphore_timeout_cnt.sv
// Saturating blocked-cycle counter for the acquire wait.
// Flags the last allowed blocked cycle.
module semaphore_timeout_cnt
    import semaphore_pkg::*;
#(
    parameter int TimeoutCycles = 255,
    localparam int W = cnt_width(TimeoutCycles)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [W-1:0] Max  = '1;
    localparam logic [W-1:0] Last = W'(TimeoutCycles - 1);

    logic [W-1:0] count;

    // Count blocked cycles; hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != Max)) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (TimeoutCycles != 0) && (count == Last);

endmodule

// File: rtl/semaphore_client.sv
// Per-core client FSM for a hardware semaphore array.
// Acquire waits on blocking with optional timeout; release is one shot.
module semaphore_client
    import semaphore_pkg::*;
#(
    parameter int NumberOfSemaphores = 4,
    parameter int TimeoutCycles = 255,
    localparam int IdWidth = id_width(NumberOfSemaphores)
) (
    input  logic                          CLK,
    input  logic                          SEMCLIENT_RESET,
    input  logic                          SEMCLIENT_REQ,
    input  logic                          SEMCLIENT_OP,
    input  logic [IdWidth-1:0]            SEMCLIENT_ID,
    output logic                          SEMCLIENT_BUSY,
    output logic                          SEMCLIENT_DONE,
    output logic                          SEMCLIENT_TIMEOUT,
    output logic                          SEMCLIENT_ERR,
    output logic [NumberOfSemaphores-1:0] SEMCLIENT_EN,
    output logic [NumberOfSemaphores-1:0] SEMCLIENT_WR,
    input  logic [NumberOfSemaphores-1:0] SEMCLIENT_BLOCKING
);

    localparam int N = NumberOfSemaphores;
    localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             next_state;
    logic [IdWidth-1:0] id_q;
    logic               op_q;
    logic [N-1:0]       id_onehot;
    logic               id_ok;
    logic               blocked;
    logic               terminal;

    assign id_onehot = One << id_q;
    assign id_ok     = (32'(SEMCLIENT_ID) < 32'(N));
    assign blocked   = |(SEMCLIENT_BLOCKING & id_onehot);

    semaphore_timeout_cnt #(
        .TimeoutCycles(TimeoutCycles)
    ) u_cnt (
        .clk     (CLK),
        .rst     (SEMCLIENT_RESET),
        .clear   (state == S_IDLE),
        .enable  ((state == S_ACQ_WAIT) && blocked),
        .terminal(terminal)
    );

    // State register plus request capture while idle.
    always_ff @(posedge CLK or posedge SEMCLIENT_RESET) begin
        if (SEMCLIENT_RESET) begin
            state <= S_IDLE;
            id_q  <= '0;
            op_q  <= OP_ACQUIRE;
        end else begin
            state <= next_state;
            if ((state == S_IDLE) && SEMCLIENT_REQ) begin
                id_q <= SEMCLIENT_ID;
                op_q <= SEMCLIENT_OP;
            end
        end
    end

    // Next state and outputs decoded from the registered state.
    always_comb begin
        next_state        = state;
        SEMCLIENT_BUSY    = 1'b1;
        SEMCLIENT_DONE    = 1'b0;
        SEMCLIENT_TIMEOUT = 1'b0;
        SEMCLIENT_ERR     = 1'b0;
        SEMCLIENT_EN      = '0;
        SEMCLIENT_WR      = '0;
        unique case (state)
            S_IDLE: begin
                SEMCLIENT_BUSY = 1'b0;
                if (SEMCLIENT_REQ) begin
                    if (!id_ok) begin
                        next_state = S_ERR;
                    end else if (SEMCLIENT_OP == OP_RELEASE) begin
                        next_state = S_REL;
                    end else begin
                        next_state = S_ACQ_WAIT;
                    end
                end
            end
            S_ACQ_WAIT: begin
                SEMCLIENT_EN = id_onehot;
                // A release seen on the limit cycle still wins.
                if (!blocked) begin
                    next_state = S_ACQ_TAKE;
                end else if (terminal) begin
                    next_state = S_TOUT;
                end
            end
            S_ACQ_TAKE, S_REL: begin
                SEMCLIENT_DONE = 1'b1;
                SEMCLIENT_WR   = id_onehot;
                if (op_q == OP_ACQUIRE) begin
                    SEMCLIENT_EN = id_onehot;
                end
                next_state = S_IDLE;
            end
            S_TOUT: begin
                SEMCLIENT_TIMEOUT = 1'b1;
                next_state        = S_IDLE;
            end
            S_ERR: begin
                SEMCLIENT_ERR = 1'b1;
                next_state    = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_semaphore_client.sv
// Bench for semaphore_client: three configurations checked every cycle
// against a reference model, plus vector table and corner sequences.
module tb_semaphore_client;

    logic       clk;
    logic       rst;
    logic       req;
    logic       op;
    logic [1:0] id;
    logic [3:0] blk;

    logic [2:0] busy, done, tout, err;
    logic [3:0] en0, wr0, en1, wr1;
    logic [2:0] en2, wr2;

    int n_tests = 0;
    int n_fail  = 0;

    int cfg_n [3] = '{4, 4, 3};
    int cfg_t [3] = '{255, 8, 0};

    // Model: 0 idle, 1 waiting, 2 taking, 3 releasing, 4 timeout, 5 error
    int ph   [3];
    int mid  [3];
    int nblk [3];

    semaphore_client #(.NumberOfSemaphores(4), .TimeoutCycles(255)) dut_a (
        .CLK(clk), .SEMCLIENT_RESET(rst), .SEMCLIENT_REQ(req),
        .SEMCLIENT_OP(op), .SEMCLIENT_ID(id), .SEMCLIENT_BUSY(busy[0]),
        .SEMCLIENT_DONE(done[0]), .SEMCLIENT_TIMEOUT(tout[0]),
        .SEMCLIENT_ERR(err[0]), .SEMCLIENT_EN(en0), .SEMCLIENT_WR(wr0),
        .SEMCLIENT_BLOCKING(blk)
    );

    semaphore_client #(.NumberOfSemaphores(4), .TimeoutCycles(8)) dut_b (
        .CLK(clk), .SEMCLIENT_RESET(rst), .SEMCLIENT_REQ(req),
        .SEMCLIENT_OP(op), .SEMCLIENT_ID(id), .SEMCLIENT_BUSY(busy[1]),
        .SEMCLIENT_DONE(done[1]), .SEMCLIENT_TIMEOUT(tout[1]),
        .SEMCLIENT_ERR(err[1]), .SEMCLIENT_EN(en1), .SEMCLIENT_WR(wr1),
        .SEMCLIENT_BLOCKING(blk)
    );

    semaphore_client #(.NumberOfSemaphores(3), .TimeoutCycles(0)) dut_c (
        .CLK(clk), .SEMCLIENT_RESET(rst), .SEMCLIENT_REQ(req),
        .SEMCLIENT_OP(op), .SEMCLIENT_ID(id), .SEMCLIENT_BUSY(busy[2]),
        .SEMCLIENT_DONE(done[2]), .SEMCLIENT_TIMEOUT(tout[2]),
        .SEMCLIENT_ERR(err[2]), .SEMCLIENT_EN(en2), .SEMCLIENT_WR(wr2),
        .SEMCLIENT_BLOCKING(blk[2:0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] got_out(input int c);
        case (c)
            0: return {busy[0], done[0], tout[0], err[0], en0, wr0};
            1: return {busy[1], done[1], tout[1], err[1], en1, wr1};
            default: return {busy[2], done[2], tout[2], err[2],
                             1'b0, en2, 1'b0, wr2};
        endcase
    endfunction

    function automatic logic [11:0] model_out(input int c);
        logic [3:0] oh;
        logic [3:0] e;
        logic [3:0] w;
        oh = 4'b0001 << mid[c];
        e  = (ph[c] == 1 || ph[c] == 2) ? oh : 4'b0000;
        w  = (ph[c] == 2 || ph[c] == 3) ? oh : 4'b0000;
        return {ph[c] != 0, ph[c] == 2 || ph[c] == 3,
                ph[c] == 4, ph[c] == 5, e, w};
    endfunction

    task automatic check(input string name, input logic [11:0] got,
                         input logic [11:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model stepped at each active edge from the rules.
    initial begin
        for (int c = 0; c < 3; c++) begin
            ph[c] = 0; mid[c] = 0; nblk[c] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int c = 0; c < 3; c++) begin
                if (rst) begin
                    ph[c] = 0; mid[c] = 0; nblk[c] = 0;
                end else if (ph[c] == 0) begin
                    if (req) begin
                        mid[c] = int'(id);
                        if (int'(id) >= cfg_n[c]) ph[c] = 5;
                        else if (op) ph[c] = 3;
                        else begin ph[c] = 1; nblk[c] = 0; end
                    end
                end else if (ph[c] == 1) begin
                    if (!blk[mid[c]]) ph[c] = 2;
                    else if (cfg_t[c] != 0 && nblk[c] + 1 >= cfg_t[c]) ph[c] = 4;
                    else nblk[c] = nblk[c] + 1;
                end else begin
                    ph[c] = 0;
                end
            end
        end
    end

    // Every DUT compared with the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < 3; c++)
                check($sformatf("model_c%0d", c), got_out(c), model_out(c));
        end
    end

    typedef struct packed {
        logic       req;
        logic       op;
        logic [1:0] id;
        logic [3:0] blk;
        logic       busy;
        logic       done;
        logic [3:0] en;
        logic [3:0] wr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int e, t, waits;
        logic wr_seen;

        rst = 1'b1; req = 1'b0; op = 1'b0; id = 2'd0; blk = 4'b0000;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++)
            check($sformatf("reset_c%0d", c), got_out(c), 12'h000);
        #2 rst = 1'b0;

        // req op id blk | busy done en wr (expected for dut_a)
        tbl[0] = '{1'b1, 1'b0, 2'd2, 4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0000};
        tbl[1] = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0100};
        tbl[2] = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[3] = '{1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0001};
        tbl[4] = '{1'b1, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[5] = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[6] = '{1'b1, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000};
        tbl[7] = '{1'b0, 1'b0, 2'd0, 4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000};
        tbl[8] = '{1'b0, 1'b0, 2'd0, 4'b1101, 1'b1, 1'b1, 4'b0010, 4'b0010};
        tbl[9] = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000};

        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req; op = tbl[i].op; id = tbl[i].id; blk = tbl[i].blk;
            @(negedge clk);
            check($sformatf("tbl%0d", i),
                  {2'b00, busy[0], done[0], en0, wr0},
                  {2'b00, tbl[i].busy, tbl[i].done, tbl[i].en, tbl[i].wr});
        end

        // Blocked acquire that is released after a few cycles.
        req = 1'b1; op = 1'b0; id = 2'd1; blk = 4'b0010;
        waits = 0;
        repeat (5) begin
            @(negedge clk);
            req = 1'b0;
            if (busy[0] && en0 == 4'b0010 && wr0 == 4'b0000) waits++;
        end
        blk = 4'b0000;
        @(negedge clk);
        check("blocked_waits", 12'(waits), 12'd5);
        check("blocked_take", {4'b0, done[0], tout[0], 2'b0, wr0},
              {4'b0, 1'b1, 1'b0, 2'b0, 4'b0010});
        @(negedge clk);
        check("blocked_idle", {11'b0, busy[0]}, 12'h000);

        // Timeout after eight blocked cycles, no write issued.
        req = 1'b1; op = 1'b0; id = 2'd3; blk = 4'b1000;
        e = -1; t = -1; wr_seen = 1'b0;
        for (int i = 1; i <= 40 && t < 0; i++) begin
            @(negedge clk);
            req = 1'b0;
            if (e < 0 && en1 == 4'b1000) e = i;
            if (tout[1]) t = i;
            if (wr1 != 4'b0000) wr_seen = 1'b1;
        end
        check("tout_seen", {11'b0, t > 0}, 12'h001);
        check("tout_delay", 12'(t - e), 12'd8);
        check("tout_no_wr", {11'b0, wr_seen}, 12'h000);
        blk = 4'b0000;
        repeat (3) @(negedge clk);

        // Release arriving on the limit cycle still completes the acquire.
        req = 1'b1; op = 1'b0; id = 2'd3; blk = 4'b1000;
        @(negedge clk);
        req = 1'b0;
        repeat (7) @(negedge clk);
        blk = 4'b0000;
        @(negedge clk);
        check("tie_take", {3'b0, done[1], tout[1], 3'b0, wr1},
              {3'b0, 1'b1, 1'b0, 3'b0, 4'b1000});
        @(negedge clk);

        // Out-of-range id on the three-entry array.
        req = 1'b1; op = 1'b0; id = 2'd3; blk = 4'b0000;
        @(negedge clk);
        req = 1'b0;
        check("err_pulse", {err[2], 1'b0, done[2], 1'b0, 1'b0, en2, 1'b0, wr2},
              {1'b1, 11'b0});
        @(negedge clk);
        check("err_clear", {11'b0, err[2]}, 12'h000);
        repeat (2) @(negedge clk);

        // Reset asserted between edges while waiting clears outputs at once.
        req = 1'b1; op = 1'b0; id = 2'd2; blk = 4'b0100;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("pre_reset_wait", {8'b0, en0}, {8'b0, 4'b0100});
        #2 rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++)
            check($sformatf("async_reset_c%0d", c), got_out(c), 12'h000);
        @(negedge clk);
        req = 1'b1; op = 1'b1; id = 2'd0; blk = 4'b0000;
        #2 rst = 1'b0;
        @(negedge clk);
        req = 1'b0;
        check("first_req", {7'b0, busy[0], wr0}, {7'b0, 1'b1, 4'b0001});
        @(negedge clk);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            req = ($urandom % 3) == 0;
            op  = $urandom_range(1, 0);
            id  = 2'($urandom);
            if (($urandom % 4) == 0)
                blk = 4'($urandom) | 4'($urandom);
            if (($urandom % 500) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            @(negedge clk);
        end

        req = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
